rv_boot_seq: RTL and testbench

Parametrised boot and run sequencer for the nanorv32 system. It replaces the hand-driven reset, register-file-clear and run-length logic of the bench with synthesizable RTL that is shared by simulation and FPGA. It sits between the board/bench reset and the `nanorv32` core reset. It clears the core's register-file copies and, optionally, the byte-lane data memories. It then releases the core and supervises the run with a halt detector and a cycle watchdog.

---
 rtl/rv_boot_pkg.sv | 31 +++
 rtl/rv_sat_counter.sv | 26 ++
 rtl/rv_boot_seq.sv | 160 ++++++++++++++++
 tb/tb_rv_boot_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_boot_pkg.sv
// Shared types and helpers for the nanorv32 boot/run sequencer.
package rv_boot_pkg;

    typedef enum logic [2:0] {
        PRE     = 3'd0,
        RF_CLR  = 3'd1,
        MEM_CLR = 3'd2,
        HOLD    = 3'd3,
        RUN     = 3'd4,
        DONE    = 3'd5,
        TIMEOUT = 3'd6
    } boot_state_t;

    // Number of cycles spent in a timed boot phase; untimed states report 1.
    function automatic int unsigned phase_len(
        input boot_state_t st,
        input int unsigned pre_cycles,
        input int unsigned rf_depth,
        input int unsigned mem_aw,
        input int unsigned hold_cycles
    );
        case (st)
            PRE:     phase_len = pre_cycles;
            RF_CLR:  phase_len = rf_depth;
            MEM_CLR: phase_len = 32'd1 << mem_aw;
            HOLD:    phase_len = hold_cycles;
            default: phase_len = 32'd1;
        endcase
    endfunction

endpackage

// File: rtl/rv_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module rv_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset_l,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/rv_boot_seq.sv
// Boot and run sequencer for nanorv32: clears register files and optionally
// data memories, releases the core, then supervises the run (halt, watchdog).
module rv_boot_seq
    import rv_boot_pkg::*;
#(
    parameter int unsigned RF_DEPTH    = 32,
    parameter int unsigned MEM_LANES   = 4,
    parameter int unsigned MEM_AW      = 10,
    parameter int unsigned CLEAR_MEM   = 0,
    parameter int unsigned PRE_CYCLES  = 2,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned MAX_CYCLES  = 1000,
    parameter int unsigned CW          = 32
) (
    input  logic                        clk,
    input  logic                        reset_l,
    input  logic                        restart,
    input  logic                        halt,
    output logic                        core_reset_l,
    output logic                        rf_we,
    output logic [$clog2(RF_DEPTH)-1:0] rf_waddr,
    output logic [31:0]                 rf_wdata,
    output logic [MEM_LANES-1:0]        mem_we,
    output logic [MEM_AW-1:0]           mem_waddr,
    output logic                        busy,
    output logic                        running,
    output logic                        done,
    output logic                        timeout,
    output logic [CW-1:0]               cycle_count
);

    localparam int unsigned RF_AW  = $clog2(RF_DEPTH);
    localparam int unsigned W_MEM  = MEM_AW + 1;
    localparam int unsigned W_RF   = RF_AW + 1;
    localparam int unsigned W_PRE  = $clog2(PRE_CYCLES + 1);
    localparam int unsigned W_HOLD = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned W_A    = (W_MEM > W_RF) ? W_MEM : W_RF;
    localparam int unsigned W_B    = (W_PRE > W_HOLD) ? W_PRE : W_HOLD;
    localparam int unsigned PW     = (W_A > W_B) ? W_A : W_B;

    boot_state_t          r_state;
    boot_state_t          w_state_nxt;
    logic [PW-1:0]        r_cnt;
    logic [PW-1:0]        w_cnt_nxt;
    logic [PW-1:0]        w_up;
    logic [PW-1:0]        w_up_nxt;
    int unsigned          w_len;
    logic                 w_last;
    logic                 w_expire;
    logic                 w_restart_ok;
    logic                 w_hold_cnt;
    logic [CW-1:0]        w_cycle_count;

    logic                 r_core_reset_l;
    logic                 r_rf_we;
    logic [RF_AW-1:0]     r_rf_waddr;
    logic [31:0]          r_rf_wdata;
    logic [MEM_LANES-1:0] r_mem_we;
    logic [MEM_AW-1:0]    r_mem_waddr;
    logic                 r_busy;
    logic                 r_running;
    logic                 r_done;
    logic                 r_timeout;

    // The phase counter counts down from 0; its negation is the elapsed-cycle view.
    assign w_up = PW'(0) - r_cnt;

    // Next-state and phase-counter update.
    always_comb begin
        w_state_nxt  = r_state;
        w_restart_ok = 1'b0;
        w_len        = phase_len(r_state, PRE_CYCLES, RF_DEPTH, MEM_AW, HOLD_CYCLES);
        w_last       = (w_up == PW'(w_len - 32'd1));
        w_expire     = (MAX_CYCLES != 0) && (w_cycle_count == CW'(MAX_CYCLES - 32'd1));

        case (r_state)
            PRE:     if (w_last) w_state_nxt = RF_CLR;
            RF_CLR:  if (w_last) w_state_nxt = (CLEAR_MEM != 0) ? MEM_CLR : HOLD;
            MEM_CLR: if (w_last) w_state_nxt = HOLD;
            HOLD:    if (w_last) w_state_nxt = RUN;
            RUN: begin
                if (restart) begin
                    w_state_nxt  = PRE;
                    w_restart_ok = 1'b1;
                end else if (halt) begin
                    w_state_nxt = DONE;
                end else if (w_expire) begin
                    w_state_nxt = TIMEOUT;
                end
            end
            DONE, TIMEOUT: begin
                if (restart) begin
                    w_state_nxt  = PRE;
                    w_restart_ok = 1'b1;
                end
            end
            default: w_state_nxt = PRE;
        endcase

        w_hold_cnt = (w_state_nxt != r_state) || (w_state_nxt == RUN) ||
                     (w_state_nxt == DONE) || (w_state_nxt == TIMEOUT);
        w_cnt_nxt  = w_hold_cnt ? '0 : (r_cnt - PW'(1));
        w_up_nxt   = PW'(0) - w_cnt_nxt;
    end

    // State register and registered outputs, derived from the upcoming state.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state        <= PRE;
            r_cnt          <= '0;
            r_core_reset_l <= 1'b0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= '0;
            r_mem_we       <= '0;
            r_mem_waddr    <= '0;
            r_busy         <= 1'b1;
            r_running      <= 1'b0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_core_reset_l <= (w_state_nxt == RUN);
            r_rf_we        <= (w_state_nxt == RF_CLR);
            r_rf_waddr     <= (w_state_nxt == RF_CLR) ? RF_AW'(w_up_nxt) : '0;
            r_rf_wdata     <= '0;
            r_mem_we       <= (w_state_nxt == MEM_CLR) ? {MEM_LANES{1'b1}} : '0;
            r_mem_waddr    <= (w_state_nxt == MEM_CLR) ? MEM_AW'(w_up_nxt) : '0;
            r_busy         <= (w_state_nxt == PRE) || (w_state_nxt == RF_CLR) ||
                              (w_state_nxt == MEM_CLR) || (w_state_nxt == HOLD);
            r_running      <= (w_state_nxt == RUN);
            r_done         <= (w_state_nxt == DONE);
            r_timeout      <= (w_state_nxt == TIMEOUT);
        end
    end

    rv_sat_counter #(
        .W (CW)
    ) u_cycle_cnt (
        .clk     (clk),
        .reset_l (reset_l),
        .clr     (w_restart_ok),
        .en      (r_state == RUN),
        .q       (w_cycle_count)
    );

    assign core_reset_l = r_core_reset_l;
    assign rf_we        = r_rf_we;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;
    assign mem_we       = r_mem_we;
    assign mem_waddr    = r_mem_waddr;
    assign busy         = r_busy;
    assign running      = r_running;
    assign done         = r_done;
    assign timeout      = r_timeout;
    assign cycle_count  = w_cycle_count;

endmodule

// File: tb/tb_rv_boot_seq.sv
// Directed self-checking bench for rv_boot_seq (default, memory-clear and short-watchdog builds).
module tb_rv_boot_seq;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // d0: defaults
    logic        restart0 = 1'b0, halt0 = 1'b0;
    logic        crl0, rfwe0, busy0, run0, done0, to0;
    logic [4:0]  rfa0;
    logic [31:0] rfd0, cc0;
    logic [3:0]  mwe0;
    logic [9:0]  mwa0;

    // d1: CLEAR_MEM=1, MEM_AW=4
    logic        restart1 = 1'b0, halt1 = 1'b0;
    logic        crl1, rfwe1, busy1, run1, done1, to1;
    logic [4:0]  rfa1;
    logic [31:0] rfd1, cc1;
    logic [3:0]  mwe1;
    logic [3:0]  mwa1;

    // d2: MAX_CYCLES=5
    logic        restart2 = 1'b0, halt2 = 1'b0;
    logic        crl2, rfwe2, busy2, run2, done2, to2;
    logic [4:0]  rfa2;
    logic [31:0] rfd2, cc2;
    logic [3:0]  mwe2;
    logic [9:0]  mwa2;

    rv_boot_seq u_d0 (
        .clk(clk), .reset_l(reset_l), .restart(restart0), .halt(halt0),
        .core_reset_l(crl0), .rf_we(rfwe0), .rf_waddr(rfa0), .rf_wdata(rfd0),
        .mem_we(mwe0), .mem_waddr(mwa0), .busy(busy0), .running(run0),
        .done(done0), .timeout(to0), .cycle_count(cc0)
    );

    rv_boot_seq #(.CLEAR_MEM(1), .MEM_AW(4)) u_d1 (
        .clk(clk), .reset_l(reset_l), .restart(restart1), .halt(halt1),
        .core_reset_l(crl1), .rf_we(rfwe1), .rf_waddr(rfa1), .rf_wdata(rfd1),
        .mem_we(mwe1), .mem_waddr(mwa1), .busy(busy1), .running(run1),
        .done(done1), .timeout(to1), .cycle_count(cc1)
    );

    rv_boot_seq #(.MAX_CYCLES(5)) u_d2 (
        .clk(clk), .reset_l(reset_l), .restart(restart2), .halt(halt2),
        .core_reset_l(crl2), .rf_we(rfwe2), .rf_waddr(rfa2), .rf_wdata(rfd2),
        .mem_we(mwe2), .mem_waddr(mwa2), .busy(busy2), .running(run2),
        .done(done2), .timeout(to2), .cycle_count(cc2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset over two edges, release 1 time unit after an edge.
    task automatic do_reset();
        restart0 = 1'b0; halt0 = 1'b0;
        restart1 = 1'b0; halt1 = 1'b0;
        restart2 = 1'b0; halt2 = 1'b0;
        #2 reset_l = 1'b0;
        tick();
        tick();
        reset_l = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_l = 1'b0;
        #2;
        n_checks++; if (crl0 !== 1'b0) begin n_errors++; $display("FAIL reset_core_reset_l got %b want 0", crl0); end
        n_checks++; if (rfwe0 !== 1'b0) begin n_errors++; $display("FAIL reset_rf_we got %b want 0", rfwe0); end
        n_checks++; if (rfa0 !== 5'd0) begin n_errors++; $display("FAIL reset_rf_waddr got %0d want 0", rfa0); end
        n_checks++; if (rfd0 !== 32'd0) begin n_errors++; $display("FAIL reset_rf_wdata got %h want 0", rfd0); end
        n_checks++; if (mwe0 !== 4'h0) begin n_errors++; $display("FAIL reset_mem_we got %h want 0", mwe0); end
        n_checks++; if (mwa0 !== 10'd0) begin n_errors++; $display("FAIL reset_mem_waddr got %0d want 0", mwa0); end
        n_checks++; if (busy0 !== 1'b1) begin n_errors++; $display("FAIL reset_busy got %b want 1", busy0); end
        n_checks++; if (run0 !== 1'b0) begin n_errors++; $display("FAIL reset_running got %b want 0", run0); end
        n_checks++; if (done0 !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", done0); end
        n_checks++; if (to0 !== 1'b0) begin n_errors++; $display("FAIL reset_timeout got %b want 0", to0); end
        n_checks++; if (cc0 !== 32'd0) begin n_errors++; $display("FAIL reset_cycle_count got %0d want 0", cc0); end
    endtask

    // Edge k after release: PRE 1, RF_CLR 2..33 (addr k-2), HOLD 34..35, RUN from 36.
    task automatic test_default_boot();
        logic       e_we, e_crl, e_busy;
        logic [4:0] e_a;
        do_reset();
        for (int k = 1; k <= 36; k++) begin
            tick();
            e_we   = (k >= 2) && (k <= 33);
            e_a    = e_we ? 5'(k - 2) : 5'd0;
            e_crl  = (k == 36);
            e_busy = (k < 36);
            n_checks++; if (rfwe0 !== e_we) begin n_errors++; $display("FAIL boot_rf_we edge %0d got %b want %b", k, rfwe0, e_we); end
            n_checks++; if (rfa0 !== e_a) begin n_errors++; $display("FAIL boot_rf_waddr edge %0d got %0d want %0d", k, rfa0, e_a); end
            n_checks++; if (crl0 !== e_crl) begin n_errors++; $display("FAIL boot_core_reset_l edge %0d got %b want %b", k, crl0, e_crl); end
            n_checks++; if (busy0 !== e_busy) begin n_errors++; $display("FAIL boot_busy edge %0d got %b want %b", k, busy0, e_busy); end
            n_checks++; if (mwe0 !== 4'h0) begin n_errors++; $display("FAIL boot_mem_we edge %0d got %h want 0", k, mwe0); end
        end
        n_checks++; if (run0 !== 1'b1) begin n_errors++; $display("FAIL boot_running got %b want 1", run0); end
        n_checks++; if (cc0 !== 32'd0) begin n_errors++; $display("FAIL boot_cycle_count_start got %0d want 0", cc0); end
    endtask

    // Continues from RUN entry: timeout expected exactly 1000 edges later.
    task automatic test_timeout();
        int seen = -1;
        for (int j = 1; j <= 1100 && seen < 0; j++) begin
            tick();
            if (to0 === 1'b1) seen = j;
        end
        n_checks++; if (seen != 1000) begin n_errors++; $display("FAIL timeout_latency got %0d want 1000", seen); end
        n_checks++; if (cc0 !== 32'd1000) begin n_errors++; $display("FAIL timeout_cycle_count got %0d want 1000", cc0); end
        n_checks++; if (crl0 !== 1'b0) begin n_errors++; $display("FAIL timeout_core_reset_l got %b want 0", crl0); end
        n_checks++; if (done0 !== 1'b0) begin n_errors++; $display("FAIL timeout_done got %b want 0", done0); end
        repeat (5) tick();
        n_checks++; if (cc0 !== 32'd1000) begin n_errors++; $display("FAIL timeout_frozen got %0d want 1000", cc0); end
        n_checks++; if (to0 !== 1'b1) begin n_errors++; $display("FAIL timeout_sticky got %b want 1", to0); end
    endtask

    // From TIMEOUT: restart returns to PRE and the whole 36-edge boot repeats.
    task automatic test_restart_timeout();
        int seen = -1;
        restart0 = 1'b1;
        tick();
        restart0 = 1'b0;
        n_checks++; if (busy0 !== 1'b1) begin n_errors++; $display("FAIL restart_busy got %b want 1", busy0); end
        n_checks++; if (crl0 !== 1'b0) begin n_errors++; $display("FAIL restart_core_reset_l got %b want 0", crl0); end
        n_checks++; if (cc0 !== 32'd0) begin n_errors++; $display("FAIL restart_cycle_count got %0d want 0", cc0); end
        n_checks++; if (to0 !== 1'b0) begin n_errors++; $display("FAIL restart_timeout got %b want 0", to0); end
        tick();
        tick();
        n_checks++; if (rfwe0 !== 1'b1 || rfa0 !== 5'd0) begin n_errors++; $display("FAIL restart_rf_first got we=%b a=%0d want we=1 a=0", rfwe0, rfa0); end
        for (int j = 3; j <= 100 && seen < 0; j++) begin
            tick();
            if (crl0 === 1'b1) seen = j;
        end
        n_checks++; if (seen != 36) begin n_errors++; $display("FAIL restart_release_latency got %0d want 36", seen); end
    endtask

    task automatic test_restart_ignored();
        int seen = -1;
        do_reset();
        repeat (10) tick();
        restart0 = 1'b1;
        tick();
        restart0 = 1'b0;
        n_checks++; if (rfa0 !== 5'd9 || rfwe0 !== 1'b1) begin n_errors++; $display("FAIL ignore_rf_addr got we=%b a=%0d want we=1 a=9", rfwe0, rfa0); end
        n_checks++; if (busy0 !== 1'b1) begin n_errors++; $display("FAIL ignore_busy got %b want 1", busy0); end
        for (int j = 12; j <= 100 && seen < 0; j++) begin
            tick();
            if (crl0 === 1'b1) seen = j;
        end
        n_checks++; if (seen != 36) begin n_errors++; $display("FAIL ignore_release_latency got %0d want 36", seen); end
    endtask

    // Halt on 10th RUN cycle (cycle_count shows 9 during it).
    task automatic test_halt();
        do_reset();
        repeat (36) tick();
        repeat (9) tick();
        n_checks++; if (cc0 !== 32'd9) begin n_errors++; $display("FAIL halt_pre_count got %0d want 9", cc0); end
        halt0 = 1'b1;
        tick();
        halt0 = 1'b0;
        n_checks++; if (done0 !== 1'b1) begin n_errors++; $display("FAIL halt_done got %b want 1", done0); end
        n_checks++; if (cc0 !== 32'd10) begin n_errors++; $display("FAIL halt_cycle_count got %0d want 10", cc0); end
        n_checks++; if (to0 !== 1'b0) begin n_errors++; $display("FAIL halt_timeout got %b want 0", to0); end
        n_checks++; if (crl0 !== 1'b0 || run0 !== 1'b0) begin n_errors++; $display("FAIL halt_core got crl=%b run=%b want 0 0", crl0, run0); end
        repeat (4) tick();
        n_checks++; if (done0 !== 1'b1 || cc0 !== 32'd10) begin n_errors++; $display("FAIL halt_sticky got done=%b cc=%0d want 1 10", done0, cc0); end
    endtask

    // MEM_AW=4 build: RF 2..33, MEM_CLR 34..49 (addr k-34), HOLD 50..51, RUN 52.
    task automatic test_clear_mem();
        logic [3:0] e_we, e_a;
        logic       e_crl;
        int         n_mem = 0;
        do_reset();
        for (int k = 1; k <= 52; k++) begin
            tick();
            e_we  = ((k >= 34) && (k <= 49)) ? 4'hF : 4'h0;
            e_a   = (e_we != 4'h0) ? 4'(k - 34) : 4'd0;
            e_crl = (k == 52);
            if (mwe1 === 4'hF) n_mem++;
            n_checks++; if (mwe1 !== e_we) begin n_errors++; $display("FAIL mem_we edge %0d got %h want %h", k, mwe1, e_we); end
            n_checks++; if (mwa1 !== e_a) begin n_errors++; $display("FAIL mem_waddr edge %0d got %0d want %0d", k, mwa1, e_a); end
            n_checks++; if (crl1 !== e_crl) begin n_errors++; $display("FAIL mem_core_reset_l edge %0d got %b want %b", k, crl1, e_crl); end
        end
        n_checks++; if (n_mem != 16) begin n_errors++; $display("FAIL mem_we_cycles got %0d want 16", n_mem); end
    endtask

    // MAX_CYCLES=5: halt during the 5th RUN cycle coincides with expiry; done wins.
    task automatic test_coincide();
        do_reset();
        repeat (36) tick();
        repeat (4) tick();
        n_checks++; if (cc2 !== 32'd4 || run2 !== 1'b1) begin n_errors++; $display("FAIL coin_pre got cc=%0d run=%b want 4 1", cc2, run2); end
        halt2 = 1'b1;
        tick();
        halt2 = 1'b0;
        n_checks++; if (done2 !== 1'b1) begin n_errors++; $display("FAIL coin_done got %b want 1", done2); end
        n_checks++; if (to2 !== 1'b0) begin n_errors++; $display("FAIL coin_timeout got %b want 0", to2); end
        n_checks++; if (cc2 !== 32'd5) begin n_errors++; $display("FAIL coin_cycle_count got %0d want 5", cc2); end
    endtask

    // Reset asserted between edges mid-RUN must act before the next edge.
    task automatic test_async_reset();
        do_reset();
        repeat (40) tick();
        n_checks++; if (run0 !== 1'b1 || cc0 !== 32'd4) begin n_errors++; $display("FAIL async_pre got run=%b cc=%0d want 1 4", run0, cc0); end
        #2 reset_l = 1'b0;
        #1;
        n_checks++; if (crl0 !== 1'b0) begin n_errors++; $display("FAIL async_core_reset_l got %b want 0", crl0); end
        n_checks++; if (run0 !== 1'b0) begin n_errors++; $display("FAIL async_running got %b want 0", run0); end
        n_checks++; if (busy0 !== 1'b1) begin n_errors++; $display("FAIL async_busy got %b want 1", busy0); end
        n_checks++; if (cc0 !== 32'd0) begin n_errors++; $display("FAIL async_cycle_count got %0d want 0", cc0); end
        tick();
        reset_l = 1'b1;
    endtask

    initial begin
        test_reset();
        test_default_boot();
        test_timeout();
        test_restart_timeout();
        test_restart_ignored();
        test_halt();
        test_clear_mem();
        test_coincide();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
